uart_rx_deframer: RTL and testbench

- Serial UART receiver that deframes the 11-bit frame sent by the system's UART transmitter: start, 8 data bits LSB first, even parity, stop.
- Oversamples the line at 16x the selected baud rate, validates the start bit and samples each bit at mid-bit.
- Presents the byte with a one-cycle valid strobe plus parity/framing error flags.
- Feeds the LED-display path and serves as the loopback checker for the transmitter.

---
 rtl/uart_rx_deframer.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Receives 11-bit UART frames (start, 8 data bits LSB first, even parity,
// stop) using 16x oversampling. Each completed frame is presented with a
// one-cycle valid strobe. Parity and framing error flags are delivered with it.
//
// Ports:
//   clk          system clock (CLK_HZ)
//   reset        asynchronous, active-low reset
//   baud_select  rate code, latched when a start bit is detected
//   Rx_EN        receiver enable; low aborts any frame and holds outputs
//   RxD          serial line, idle high, asynchronous to clk
//   Rx_DATA      last received byte
//   Rx_VALID     one-cycle strobe when a frame completes
//   Rx_PERROR    parity error of the last frame
//   Rx_FERROR    stop-bit error of the last frame
//
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to decide every bit by a
// 2-of-3 vote of the samples at ticks 7, 8 and 9 of the bit. The decision
// then happens at tick 9. Without it, a single sample is taken at tick 8.
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16,
    parameter int CLK_HZ     = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    // Divider = CLK_HZ / (OVERSAMPLE * baud), rounded to nearest.
    localparam logic [13:0] DIV_300    = 14'((CLK_HZ + OVERSAMPLE * 300 / 2) / (OVERSAMPLE * 300));
    localparam logic [13:0] DIV_1200   = 14'((CLK_HZ + OVERSAMPLE * 1200 / 2) / (OVERSAMPLE * 1200));
    localparam logic [13:0] DIV_4800   = 14'((CLK_HZ + OVERSAMPLE * 4800 / 2) / (OVERSAMPLE * 4800));
    localparam logic [13:0] DIV_9600   = 14'((CLK_HZ + OVERSAMPLE * 9600 / 2) / (OVERSAMPLE * 9600));
    localparam logic [13:0] DIV_19200  = 14'((CLK_HZ + OVERSAMPLE * 19200 / 2) / (OVERSAMPLE * 19200));
    localparam logic [13:0] DIV_38400  = 14'((CLK_HZ + OVERSAMPLE * 38400 / 2) / (OVERSAMPLE * 38400));
    localparam logic [13:0] DIV_57600  = 14'((CLK_HZ + OVERSAMPLE * 57600 / 2) / (OVERSAMPLE * 57600));
    localparam logic [13:0] DIV_115200 = 14'((CLK_HZ + OVERSAMPLE * 115200 / 2) / (OVERSAMPLE * 115200));

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] START_DECIDE = 4'd8;
`else
    localparam logic [3:0] START_DECIDE = 4'd7;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [13:0] div_val_q, div_val_d;
    logic [13:0] div_cnt_q, div_cnt_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_q, perr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_perror_q, rx_perror_d;
    logic        rx_ferror_q, rx_ferror_d;
    logic [13:0] baud_div;
    logic        tick;
    logic        falling;
    logic        bit_val;
    logic        mid_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]  hist_q, hist_d;
`endif

    // Baud code to clock divider.
    always_comb begin
        case (baud_select)
            3'b000:  baud_div = DIV_300;
            3'b001:  baud_div = DIV_1200;
            3'b010:  baud_div = DIV_4800;
            3'b011:  baud_div = DIV_9600;
            3'b100:  baud_div = DIV_19200;
            3'b101:  baud_div = DIV_38400;
            3'b110:  baud_div = DIV_57600;
            default: baud_div = DIV_115200;
        endcase
    end

    assign tick    = (div_cnt_q == div_val_q - 14'd1);
    assign falling = rxd_prev_q & ~rxd_sync_q;
    assign mid_bit = tick && (tick_cnt_q == LAST_TICK);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q holds the two previous tick samples; vote with the current one.
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_sync_q) | (hist_q[0] & rxd_sync_q);
`else
    assign bit_val = rxd_sync_q;
`endif

    // Next-state logic for the deframer FSM, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        div_val_d   = div_val_q;
        div_cnt_d   = div_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perror_d = rx_perror_q;
        rx_ferror_d = rx_ferror_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        hist_d      = hist_q;
`endif

        if (!Rx_EN) begin
            state_d    = IDLE;
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (state_q == IDLE) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            if (falling) begin
                div_val_d = baud_div;
                bit_cnt_d = '0;
                state_d   = START;
            end
        end else begin
            div_cnt_d = tick ? 14'd0 : div_cnt_q + 14'd1;
            if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
                hist_d     = {hist_q[0], rxd_sync_q};
`endif
            end

            case (state_q)
                START: begin
                    if (tick && tick_cnt_q == START_DECIDE) begin
                        if (!bit_val) begin
                            // Realign so later decisions land 16 ticks apart.
                            tick_cnt_d = '0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift_d   = {bit_val, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        perr_d  = (^shift_q) ^ bit_val;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Back to IDLE mid-stop so a back-to-back start edge is seen.
                    if (mid_bit) begin
                        rx_data_d   = shift_q;
                        rx_perror_d = perr_q;
                        rx_ferror_d = ~bit_val;
                        rx_valid_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers. Synchronizer and edge history preset to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            div_val_q   <= '0;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q      <= 2'b11;
`endif
        end else begin
            state_q     <= state_d;
            rxd_meta_q  <= RxD;
            rxd_sync_q  <= rxd_meta_q;
            rxd_prev_q  <= rxd_sync_q;
            div_val_q   <= div_val_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perror_q <= rx_perror_d;
            rx_ferror_q <= rx_ferror_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q      <= hist_d;
`endif
        end
    end

    assign Rx_DATA   = rx_data_q;
    assign Rx_VALID  = rx_valid_q;
    assign Rx_PERROR = rx_perror_q;
    assign Rx_FERROR = rx_ferror_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
// Drives whole and partial UART frames into uart_rx_deframer and compares
// every delivered byte and flag pair with a frame-level reference model.
module tb_uart_rx_deframer;

    typedef struct {
        logic [7:0] data;
        logic       perror;
        logic       ferror;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int compareCount = 0;
    int failCount    = 0;
    int cycleCount   = 0;
    int lastStartCycle = 0;

    frame_t expQ[$];
    frame_t lastExp;
    frame_t monFrame;
    int     validCycles[$];
    logic   validPrev = 1'b0;

    // Clock dividers per rate code, at 50 MHz.
    int divTable[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

    uart_rx_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int bitClocks(input logic [2:0] code);
        return divTable[code] * 16;
    endfunction

    // Every strobe must be a single cycle and must match the oldest expected frame.
    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) begin
            checkOutput("valid_width", {31'd0, validPrev}, 32'd0);
            if (validPrev !== 1'b1) begin
                validCycles.push_back(cycleCount);
                checkOutput("valid_expected", {31'd0, expQ.size() != 0}, 32'd1);
                if (expQ.size() != 0) begin
                    monFrame = expQ.pop_front();
                    checkOutput("rx_data", {24'd0, Rx_DATA}, {24'd0, monFrame.data});
                    checkOutput("rx_perror", {31'd0, Rx_PERROR}, {31'd0, monFrame.perror});
                    checkOutput("rx_ferror", {31'd0, Rx_FERROR}, {31'd0, monFrame.ferror});
                end
            end
        end
        validPrev = Rx_VALID;
    end

    // Drives frame bits firstBit..lastBit; bit 0 is start, 9 parity, 10 stop.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                                 input int bitClk, input int firstBit, input int lastBit,
                                 input logic expectIt);
        logic [10:0] bits;
        frame_t f;
        bits = {stopBit, parBit, data, 1'b0};
        if (expectIt) begin
            f.data   = data;
            f.perror = (^data) ^ parBit;
            f.ferror = ~stopBit;
            expQ.push_back(f);
            lastExp = f;
        end
        if (firstBit == 0) lastStartCycle = cycleCount;
        for (int i = firstBit; i <= lastBit; i++) begin
            RxD = bits[i];
            repeat (bitClk) @(negedge clk);
        end
    endtask

    task automatic idleBits(input int n, input int bitClk);
        RxD = 1'b1;
        repeat (n * bitClk) @(negedge clk);
    endtask

    initial begin
        int n;
        int lat;
        int b115;
        logic [7:0] rdata;
        logic perr, serr;

        b115 = bitClocks(3'b111);
        reset = 1'b0;
        RxD = 1'b1;
        Rx_EN = 1'b1;
        baud_select = 3'b111;
        repeat (5) @(negedge clk);
        checkOutput("reset_data", {24'd0, Rx_DATA}, 32'd0);
        checkOutput("reset_valid", {31'd0, Rx_VALID}, 32'd0);
        checkOutput("reset_perror", {31'd0, Rx_PERROR}, 32'd0);
        checkOutput("reset_ferror", {31'd0, Rx_FERROR}, 32'd0);
        reset = 1'b1;

        $display("[TB] idle line after reset");
        idleBits(10, b115);
        checkOutput("idle_no_valid", validCycles.size(), 32'd0);
        checkOutput("idle_data", {24'd0, Rx_DATA}, 32'd0);

        $display("[TB] nominal frame 0x94");
        n = validCycles.size();
        applyStimulus(8'h94, 1'b1, 1'b1, b115, 0, 10, 1'b1);
        checkOutput("nominal_received", expQ.size(), 32'd0);
        checkOutput("nominal_count", validCycles.size() - n, 32'd1);
        if (validCycles.size() > n) begin
            lat = validCycles[n] - lastStartCycle;
            checkOutput("latency_window", {31'd0, (lat >= b115 * 21 / 2) && (lat <= b115 * 21 / 2 + 35)}, 32'd1);
        end

        $display("[TB] back-to-back error frames");
        n = validCycles.size();
        applyStimulus(8'hA1, 1'b0, 1'b1, b115, 0, 10, 1'b1);
        applyStimulus(8'h55, 1'b0, 1'b0, b115, 0, 10, 1'b1);
        idleBits(2, b115);
        checkOutput("b2b_count", validCycles.size() - n, 32'd2);
        if (validCycles.size() >= n + 2)
            checkOutput("b2b_spacing", validCycles[n + 1] - validCycles[n], 11 * b115);
        checkOutput("hold_ferror", {31'd0, Rx_FERROR}, {31'd0, lastExp.ferror});
        checkOutput("hold_perror", {31'd0, Rx_PERROR}, {31'd0, lastExp.perror});

        $display("[TB] false start glitch");
        n = validCycles.size();
        RxD = 1'b0;
        repeat (5) @(negedge clk);
        idleBits(2, b115);
        checkOutput("false_start_no_valid", validCycles.size() - n, 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b1, b115, 0, 10, 1'b1);
        checkOutput("after_glitch_received", expQ.size(), 32'd0);

        $display("[TB] reset abort");
        n = validCycles.size();
        applyStimulus(8'h5A, 1'b0, 1'b1, b115, 0, 3, 1'b0);
        RxD = 1'b1;
        repeat (200) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_reset_data", {24'd0, Rx_DATA}, 32'd0);
        checkOutput("abort_reset_perror", {31'd0, Rx_PERROR}, 32'd0);
        checkOutput("abort_reset_ferror", {31'd0, Rx_FERROR}, 32'd0);
        reset = 1'b1;
        idleBits(2, b115);
        checkOutput("abort_reset_no_valid", validCycles.size() - n, 32'd0);
        applyStimulus(8'hF0, 1'b0, 1'b1, b115, 0, 10, 1'b1);
        checkOutput("after_reset_received", expQ.size(), 32'd0);

        $display("[TB] enable abort");
        n = validCycles.size();
        applyStimulus(8'h00, 1'b0, 1'b1, b115, 0, 4, 1'b0);
        Rx_EN = 1'b0;
        RxD = 1'b0;
        repeat (2 * b115 + b115 / 2) @(negedge clk);
        Rx_EN = 1'b1;
        repeat (b115 / 2 + 2 * b115) @(negedge clk);
        idleBits(3, b115);
        checkOutput("en_abort_no_valid", validCycles.size() - n, 32'd0);
        checkOutput("en_abort_hold_data", {24'd0, Rx_DATA}, {24'd0, lastExp.data});

        $display("[TB] rate change to 38400, select changed mid-frame");
        baud_select = 3'b101;
        applyStimulus(8'h81, 1'b0, 1'b1, bitClocks(3'b101), 0, 1, 1'b1);
        baud_select = 3'b111;
        applyStimulus(8'h81, 1'b0, 1'b1, bitClocks(3'b101), 2, 10, 1'b0);
        idleBits(1, b115);
        checkOutput("rate_change_received", expQ.size(), 32'd0);

        $display("[TB] random frames");
        for (int k = 0; k < 4; k++) begin
            rdata = 8'($urandom_range(0, 255));
            perr  = ($urandom_range(0, 3) == 0);
            serr  = ($urandom_range(0, 3) == 0);
            applyStimulus(rdata, (^rdata) ^ perr, ~serr, b115, 0, 10, 1'b1);
            if (serr || $urandom_range(0, 1) == 1) idleBits(1, b115);
            checkOutput("random_data_hold", {24'd0, Rx_DATA}, {24'd0, rdata});
        end
        idleBits(1, b115);
        checkOutput("all_frames_received", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
